if_pc_gen: RTL and testbench
============================

IF_PC_GEN -- requirements
Module: if_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have ports, clock and reset first: i_clk input 1 (sole clock); i_rst_n input 1 (reset, asynchronous, active-low).
REQ-003 i_ex_jump_taken input 1 (EX jump resolved taken); i_ex_jump_target input 64 (jump destination).
REQ-004 i_ex_branch_taken input 1 (EX branch resolved taken); i_ex_branch_target input 64 (branch destination).
REQ-005 i_stall input 1 (decode cannot accept an instruction this cycle).
REQ-006 o_imem_req output 1 (fetch request); o_imem_addr output 64 (fetch address); i_imem_gnt input 1 (request accepted).
REQ-007 i_imem_rvalid input 1 (response valid); i_imem_rdata input 32 (instruction word).
REQ-008 o_if_valid output 1 (instruction to decode); o_if_pc output 64; o_if_instr output 32.
REQ-009 o_flush output 1 (one-cycle pulse, kill younger in-flight stages); o_misaligned output 1 (one-cycle pulse, redirect target bit 0 set).

Function
REQ-010 Redirect = i_ex_jump_taken | i_ex_branch_taken; target = jump target if jump taken, else branch target (jump priority when both).
REQ-011 Redirect target bit 0 SHALL be cleared before use; o_misaligned pulses in the same cycle if that bit was 1.
REQ-012 o_flush SHALL equal redirect, combinationally, in the redirect cycle.
REQ-013 FSM states: IDLE, REQ, WAIT, DROP, HOLD.
REQ-014 IDLE: single cycle after reset release -> REQ with PC = RESET_PC.
REQ-015 REQ: o_imem_req=1, o_imem_addr=PC; on i_imem_gnt -> WAIT.
REQ-016 WAIT: on i_imem_rvalid, if i_stall=0: o_if_valid=1 same cycle with o_if_pc=PC, o_if_instr=rdata, PC+=4, -> REQ; if i_stall=1: capture into one-entry buffer, -> HOLD.
REQ-017 HOLD: o_if_valid=1 from buffer; when i_stall=0, PC+=4 -> REQ.
REQ-018 Redirect in REQ without gnt, or in HOLD: PC=target, buffer dropped, -> REQ next cycle.
REQ-019 Redirect in REQ with gnt, or in WAIT without rvalid: PC=target, -> DROP; DROP discards the next rvalid, then -> REQ.
REQ-020 Redirect in WAIT with rvalid: response discarded, PC=target, -> REQ.
REQ-021 o_if_valid SHALL be 0 whenever redirect is high, and in IDLE, REQ and DROP.
REQ-022 Redirect in DROP: PC updated to the newest target, remain in DROP.
REQ-023 PC arithmetic 64-bit, wraps modulo 2^64 without flag.
REQ-024 At most one outstanding memory request at any time.

Reset
REQ-025 On i_rst_n low (asynchronous): state=IDLE, PC=RESET_PC, buffer cleared; o_imem_req, o_if_valid, o_flush, o_misaligned = 0; o_imem_addr, o_if_pc = RESET_PC; o_if_instr = 0.
REQ-026 Reset mid-transaction SHALL abandon any outstanding request; a response arriving before the first REQ after reset SHALL be ignored.

Structure
REQ-027 FSM state enum and RESET_PC default SHALL live in struct_pckg; the 64-bit width SHALL use the shared range macro from defines.sv.
REQ-028 A single sub-module if_fetch_buf (one-entry instruction/PC holding register with valid) SHALL implement the HOLD buffer; all else stays in if_pc_gen.

Verification
REQ-029 Reset release, gnt same cycle, rvalid next cycle with 32'h00000013 -> o_imem_addr 64'h80000000, o_if_valid with o_if_pc 64'h80000000, next request addr 64'h80000004.
REQ-030 Branch taken, target 64'h80000101, while in WAIT -> o_flush and o_misaligned pulse, stale rvalid dropped, next request addr 64'h80000100.
REQ-031 Jump (target 64'h80000200) and branch (target 64'h80000300) same cycle -> next fetch 64'h80000200.
REQ-032 i_stall=1 for 3 cycles when rvalid arrives -> o_if_valid and o_if_instr held stable 3 cycles, no new request until stall drops.
REQ-033 PC 64'hFFFF_FFFF_FFFF_FFFC fetched -> next fetch addr 64'h0.
REQ-034 i_rst_n asserted while in WAIT -> outputs at reset values immediately, late rvalid ignored, first fetch at RESET_PC.

Source files
------------

// File: rtl/struct_pckg.sv
// Types and constants shared by the instruction-fetch PC generator.
`include "defines.sv"

package struct_pckg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DROP,
    ST_HOLD
  } fetch_state_t;

  localparam logic [`XLEN_RANGE] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  // Instructions are at least halfword aligned, so bit 0 of a target is dropped.
  function automatic logic [`XLEN_RANGE] align_target(input logic [`XLEN_RANGE] t);
    return {t[63:1], 1'b0};
  endfunction

endpackage

// File: rtl/defines.sv
// Shared width macros for the fetch-stage slice.
`ifndef DEFINES_SV
`define DEFINES_SV
`define XLEN       64
`define XLEN_RANGE 63:0
`endif

// File: rtl/if_fetch_buf.sv
// One-entry holding register for a fetched instruction that decode could not take.
`include "defines.sv"

module if_fetch_buf (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [`XLEN_RANGE] i_pc,
  input  logic [31:0]        i_instr,
  output logic               o_valid,
  output logic [`XLEN_RANGE] o_pc,
  output logic [31:0]        o_instr
);

  logic               valid_reg;
  logic [`XLEN_RANGE] pc_reg;
  logic [31:0]        instr_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= '0;
    end else if (i_load) begin
      valid_reg <= 1'b1;
      pc_reg    <= i_pc;
      instr_reg <= i_instr;
    end else if (i_clear) begin
      valid_reg <= 1'b0;
    end
  end

  assign o_valid = valid_reg;
  assign o_pc    = pc_reg;
  assign o_instr = instr_reg;

endmodule

// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator: single-outstanding imem request FSM with EX redirect
// handling, stale-response dropping and a one-entry stall buffer.
`include "defines.sv"

module if_pc_gen
  import struct_pckg::*;
#(
  parameter logic [`XLEN_RANGE] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ex_jump_taken,
  input  logic [`XLEN_RANGE] i_ex_jump_target,
  input  logic               i_ex_branch_taken,
  input  logic [`XLEN_RANGE] i_ex_branch_target,
  input  logic               i_stall,
  output logic               o_imem_req,
  output logic [`XLEN_RANGE] o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [31:0]        i_imem_rdata,
  output logic               o_if_valid,
  output logic [`XLEN_RANGE] o_if_pc,
  output logic [31:0]        o_if_instr,
  output logic               o_flush,
  output logic               o_misaligned
);

  fetch_state_t       state_reg;
  logic [`XLEN_RANGE] pc_reg;

  logic               redirect;
  logic [`XLEN_RANGE] target_raw;
  logic [`XLEN_RANGE] target;

  logic               buf_load;
  logic               buf_clear;
  logic               buf_valid;
  logic [`XLEN_RANGE] buf_pc;
  logic [31:0]        buf_instr;

  // IDLE is the post-reset cycle; EX cannot have anything valid to redirect with yet.
  assign redirect   = (i_ex_jump_taken | i_ex_branch_taken) && (state_reg != ST_IDLE);
  assign target_raw = i_ex_jump_taken ? i_ex_jump_target : i_ex_branch_target;
  assign target     = align_target(target_raw);

  assign o_flush      = redirect;
  assign o_misaligned = redirect & target_raw[0];

  assign buf_load  = (state_reg == ST_WAIT) && i_imem_rvalid && i_stall && !redirect;
  assign buf_clear = (state_reg == ST_HOLD) && (!i_stall || redirect);

  if_fetch_buf u_fetch_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (buf_load),
    .i_clear (buf_clear),
    .i_pc    (pc_reg),
    .i_instr (i_imem_rdata),
    .o_valid (buf_valid),
    .o_pc    (buf_pc),
    .o_instr (buf_instr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_REQ;
          pc_reg    <= RESET_PC;
        end
        ST_REQ: begin
          if (redirect) begin
            pc_reg    <= target;
            state_reg <= i_imem_gnt ? ST_DROP : ST_REQ;
          end else if (i_imem_gnt) begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect) begin
            pc_reg    <= target;
            state_reg <= i_imem_rvalid ? ST_REQ : ST_DROP;
          end else if (i_imem_rvalid) begin
            if (i_stall) begin
              state_reg <= ST_HOLD;
            end else begin
              pc_reg    <= pc_reg + 64'd4;
              state_reg <= ST_REQ;
            end
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            pc_reg    <= target;
            state_reg <= ST_REQ;
          end else if (!i_stall) begin
            pc_reg    <= pc_reg + 64'd4;
            state_reg <= ST_REQ;
          end
        end
        ST_DROP: begin
          if (redirect) begin
            pc_reg <= target;
          end
          // Leave as soon as the stale response is consumed, even on a fresh redirect,
          // otherwise nothing would ever arrive to release DROP.
          if (i_imem_rvalid) begin
            state_reg <= ST_REQ;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          pc_reg    <= RESET_PC;
        end
      endcase
    end
  end

  assign o_imem_req  = (state_reg == ST_REQ);
  assign o_imem_addr = pc_reg;

  always_comb begin
    o_if_valid = 1'b0;
    o_if_pc    = pc_reg;
    o_if_instr = '0;
    case (state_reg)
      ST_WAIT: begin
        if (i_imem_rvalid) begin
          o_if_valid = !redirect;
          o_if_instr = i_imem_rdata;
        end
      end
      ST_HOLD: begin
        o_if_valid = buf_valid && !redirect;
        o_if_pc    = buf_pc;
        o_if_instr = buf_instr;
      end
      default: begin
        o_if_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_if_pc_gen.sv
// Scoreboard bench for if_pc_gen: expected fetches queued when responses are driven,
// compared when decode accepts them.
module tb_if_pc_gen;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_taken, branch_taken, stall, gnt, rvalid;
  logic [63:0] jump_target, branch_target;
  logic [31:0] rdata;
  logic        imem_req, if_valid, flush, misaligned;
  logic [63:0] imem_addr, if_pc;
  logic [31:0] if_instr;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_pc;

  always #5 clk = ~clk;

  if_pc_gen #(.RESET_PC(RST_PC)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_ex_jump_taken    (jump_taken),
    .i_ex_jump_target   (jump_target),
    .i_ex_branch_taken  (branch_taken),
    .i_ex_branch_target (branch_target),
    .i_stall            (stall),
    .o_imem_req         (imem_req),
    .o_imem_addr        (imem_addr),
    .i_imem_gnt         (gnt),
    .i_imem_rvalid      (rvalid),
    .i_imem_rdata       (rdata),
    .o_if_valid         (if_valid),
    .o_if_pc            (if_pc),
    .o_if_instr         (if_instr),
    .o_flush            (flush),
    .o_misaligned       (misaligned)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every instruction decode accepts must match the queue head.
  always @(negedge clk) begin
    if (rst_n && if_valid && !stall) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_valid", 64'(if_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_pc", if_pc, e.pc);
        check_eq("sb_instr", 64'(if_instr), 64'(e.instr));
        $display("fetch pc=%h instr=%h", if_pc, if_instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller at a negedge with a request visible (or a failed check).
  task automatic wait_req();
    int n;
    n = 0;
    @(negedge clk);
    while (!imem_req && n < 20) begin
      step();
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", 64'(imem_req), 64'd1);
  endtask

  task automatic do_fetch(input logic [31:0] instr, input int gnt_dly, input int lat,
                          input int stall_cyc);
    wait_req();
    check_eq("req_addr", imem_addr, exp_pc);
    for (int i = 0; i < gnt_dly; i++) begin
      step();
      @(negedge clk);
      check_eq("req_hold_addr", imem_addr, exp_pc);
    end
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check_eq("one_outstanding", 64'(imem_req), 64'd0);
      step();
    end
    rvalid = 1'b1;
    rdata  = instr;
    stall  = (stall_cyc > 0);
    if (stall_cyc == 0) sb_q.push_back('{pc: exp_pc, instr: instr});
    for (int i = 0; i < stall_cyc; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 64'(if_valid), 64'd1);
      check_eq("stall_instr", 64'(if_instr), 64'(instr));
      check_eq("stall_no_req", 64'(imem_req), 64'd0);
      step();
      rvalid = 1'b0;
      rdata  = $urandom;
      if (i == stall_cyc - 1) begin
        stall = 1'b0;
        sb_q.push_back('{pc: exp_pc, instr: instr});
      end
    end
    @(negedge clk);
    step();
    rvalid = 1'b0;
    exp_pc = exp_pc + 64'd4;
  endtask

  initial begin
    rst_n = 1'b0;
    jump_taken = 1'b0; branch_taken = 1'b0; stall = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    jump_target = '0; branch_target = '0; rdata = '0;
    exp_pc = RST_PC;

    @(negedge clk);
    check_eq("rst_req", 64'(imem_req), 64'd0);
    check_eq("rst_valid", 64'(if_valid), 64'd0);
    check_eq("rst_flush", 64'(flush), 64'd0);
    check_eq("rst_misaligned", 64'(misaligned), 64'd0);
    check_eq("rst_addr", imem_addr, RST_PC);
    check_eq("rst_if_pc", if_pc, RST_PC);
    check_eq("rst_instr", 64'(if_instr), 64'd0);
    step();
    rst_n = 1'b1;

    // First fetch after reset, gnt same cycle, rvalid next cycle.
    do_fetch(32'h0000_0013, 0, 0, 0);

    // Misaligned branch while waiting: stale response must be dropped.
    wait_req();
    check_eq("req_addr_2", imem_addr, 64'h8000_0004);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    branch_taken = 1'b1; branch_target = 64'h8000_0101;
    @(negedge clk);
    check_eq("br_flush", 64'(flush), 64'd1);
    check_eq("br_misaligned", 64'(misaligned), 64'd1);
    check_eq("br_no_valid", 64'(if_valid), 64'd0);
    step();
    branch_taken = 1'b0;
    rvalid = 1'b1; rdata = 32'hdead_beef;
    @(negedge clk);
    check_eq("drop_no_valid", 64'(if_valid), 64'd0);
    check_eq("drop_no_req", 64'(imem_req), 64'd0);
    step();
    rvalid = 1'b0;
    exp_pc = 64'h8000_0100;
    do_fetch(32'h0010_0093, 1, 2, 0);

    // Jump and branch together in REQ without gnt: jump wins.
    wait_req();
    step();
    jump_taken = 1'b1;   jump_target = 64'h8000_0200;
    branch_taken = 1'b1; branch_target = 64'h8000_0300;
    @(negedge clk);
    check_eq("jb_flush", 64'(flush), 64'd1);
    check_eq("jb_misaligned", 64'(misaligned), 64'd0);
    step();
    jump_taken = 1'b0; branch_taken = 1'b0;
    exp_pc = 64'h8000_0200;
    do_fetch(32'h0020_0113, 0, 1, 0);

    // Redirect coinciding with the response: response discarded.
    wait_req();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'h1234_5678;
    branch_taken = 1'b1; branch_target = 64'h8000_0400;
    @(negedge clk);
    check_eq("rv_redir_no_valid", 64'(if_valid), 64'd0);
    check_eq("rv_redir_flush", 64'(flush), 64'd1);
    step();
    rvalid = 1'b0; branch_taken = 1'b0;
    exp_pc = 64'h8000_0400;

    // Decode stalled for three cycles when the response arrives.
    do_fetch(32'h0030_0193, 0, 0, 3);
    do_fetch(32'h0040_0213, 0, 0, 0);

    // Wrap of the PC at the top of the address space.
    wait_req();
    step();
    jump_taken = 1'b1; jump_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    jump_taken = 1'b0;
    exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    do_fetch(32'h0050_0293, 0, 0, 0);
    do_fetch(32'h0060_0313, 0, 0, 0);

    // Reset asserted mid-transaction; late response ignored.
    wait_req();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", 64'(imem_req), 64'd0);
    check_eq("mid_rst_valid", 64'(if_valid), 64'd0);
    check_eq("mid_rst_addr", imem_addr, RST_PC);
    check_eq("mid_rst_if_pc", if_pc, RST_PC);
    check_eq("mid_rst_instr", 64'(if_instr), 64'd0);
    rvalid = 1'b1; rdata = 32'hbad0_bad0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("late_rvalid_ignored", 64'(if_valid), 64'd0);
    check_eq("idle_no_req", 64'(imem_req), 64'd0);
    step();
    rvalid = 1'b0;
    exp_pc = RST_PC;
    do_fetch(32'h0070_0393, 0, 0, 0);

    @(negedge clk);
    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
